// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan decoder.
// Command modes and the two-state control FSM encoding.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

endpackage

// File: rtl/scan_decoder_onehot_decode.sv
// Combinational address to one-hot decoder with enable.
// Generalised form of the original 2-to-4 decoder.
module onehot_decode #(
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   en,
    output logic [(1<<ADDR_W)-1:0] out
);

    localparam int OUT_W = 1 << ADDR_W;

    always_comb begin
        out = '0;
        for (int i = 0; i < OUT_W; i++) begin
            out[i] = en && (addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered scan decoder: command handshake, per-step dwell
// timer and wrapping auto-increment over an address range.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_mode,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [ADDR_W-1:0]      cmd_last,
    input  logic [DWELL_W-1:0]     cmd_dwell,
    input  logic                   enable,
    input  logic                   abort,
    output logic [(1<<ADDR_W)-1:0] out,
    output logic [ADDR_W-1:0]      cur_addr,
    output logic                   busy,
    output logic                   done
);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    cur_q, cur_d;
    logic [ADDR_W-1:0]    last_q, last_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_ACTIVE;
                    cur_d   = cmd_addr;
                    last_d  = (cmd_mode == MODE_SCAN) ? cmd_last : cmd_addr;
                    dwell_d = cmd_dwell;
                    cnt_d   = '0;
                end
            end
            ST_ACTIVE: begin
                // abort outranks any step or completion on the same edge
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (enable) begin
                    if (cnt_q < dwell_q) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (cur_q == last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cur_d = cur_q + 1'b1;
                        cnt_d = '0;
                    end
                end
            end
        endcase
    end

    assign busy      = (state_q == ST_ACTIVE);
    assign cmd_ready = (state_q == ST_IDLE);
    assign cur_addr  = cur_q;
    assign done      = done_q;

    onehot_decode #(
        .ADDR_W(ADDR_W)
    ) u_dec (
        .addr(cur_q),
        .en  (enable & busy),
        .out (out)
    );

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: directed scenarios plus random traffic,
// checked against a queue model of the enabled cycles each command shows.
module tb_scan_decoder;
    import scan_decoder_pkg::*;

    localparam int AW = 3;
    localparam int DW = 4;
    localparam int NA = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_mode;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_last;
    logic [DW-1:0] cmd_dwell;
    logic          enable;
    logic          abort;
    logic [NA-1:0] dec_out;
    logic [AW-1:0] cur_addr;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    // Model: one queue entry per enabled cycle still to be shown.
    logic    m_busy;
    logic    m_done;
    int      m_cur;
    int      q[$];

    always #5 clk = ~clk;

    scan_decoder #(.ADDR_W(AW), .DWELL_W(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_mode (cmd_mode),
        .cmd_addr (cmd_addr),
        .cmd_last (cmd_last),
        .cmd_dwell(cmd_dwell),
        .enable   (enable),
        .abort    (abort),
        .out      (dec_out),
        .cur_addr (cur_addr),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_cur  = 0;
        q.delete();
    endtask

    task automatic model_edge();
        int n;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (!m_busy) begin
            if (cmd_valid) begin
                n = 1;
                if (cmd_mode == MODE_SCAN)
                    n = ((int'(cmd_last) - int'(cmd_addr) + NA) % NA) + 1;
                for (int s = 0; s < n; s++)
                    for (int k = 0; k <= int'(cmd_dwell); k++)
                        q.push_back((int'(cmd_addr) + s) % NA);
                m_cur  = int'(cmd_addr);
                m_busy = 1'b1;
            end
        end else if (abort) begin
            m_busy = 1'b0;
            q.delete();
        end else if (enable) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_cur = q[0];
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_out;
        exp_out = (m_busy && enable) ? (32'd1 << m_cur) : 32'd0;
        chk({tag, ".out"}, 32'(dec_out), exp_out);
        chk({tag, ".cur"}, 32'(cur_addr), 32'(m_cur));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".ready"}, 32'(cmd_ready), 32'(!m_busy));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic cmd(input logic mode, input logic [AW-1:0] a,
                       input logic [AW-1:0] l, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_addr  = a;
        cmd_last  = l;
        cmd_dwell = d;
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (m_busy && i < 64) begin
            cyc(tag);
            i++;
        end
        chk({tag, ".timeout"}, 32'(busy), 32'd0);
        cyc(tag);
    endtask

    initial begin
        logic [7:0] t2 [4];
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = MODE_DIRECT;
        cmd_addr  = '0;
        cmd_last  = '0;
        cmd_dwell = '0;
        enable    = 1'b1;
        abort     = 1'b0;
        model_reset();
        #2;
        check_all("rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc("idle");

        // 1: DIRECT 5, dwell 2
        cmd(MODE_DIRECT, 3'd5, 3'd0, 4'd2);
        cyc("t1");
        cmd_valid = 1'b0;
        chk("t1.onehot", 32'(dec_out), 32'h20);
        cyc("t1");
        cyc("t1");
        chk("t1.hold", 32'(dec_out), 32'h20);
        cyc("t1");
        chk("t1.done", 32'(done), 32'd1);
        chk("t1.doneout", 32'(dec_out), 32'd0);
        cyc("t1");

        // 2: SCAN 6 -> 1 wraps through 0
        t2 = '{8'h40, 8'h80, 8'h01, 8'h02};
        cmd(MODE_SCAN, 3'd6, 3'd1, 4'd0);
        for (int i = 0; i < 4; i++) begin
            cyc("t2");
            cmd_valid = 1'b0;
            chk("t2.seq", 32'(dec_out), 32'(t2[i]));
        end
        cyc("t2");
        chk("t2.done", 32'(done), 32'd1);
        cyc("t2");

        // 3: pause during step 1
        cmd(MODE_SCAN, 3'd0, 3'd3, 4'd1);
        cyc("t3");
        cmd_valid = 1'b0;
        cyc("t3");
        cyc("t3");
        enable = 1'b0;
        #1;
        chk("t3.blank", 32'(dec_out), 32'd0);
        cyc("t3");
        cyc("t3");
        chk("t3.frz", 32'(cur_addr), 32'd1);
        enable = 1'b1;
        cyc("t3");
        cyc("t3");
        chk("t3.next", 32'(cur_addr), 32'd2);
        drain("t3");

        // 4: abort mid-scan, no done pulse
        cmd(MODE_SCAN, 3'd0, 3'd7, 4'd0);
        cyc("t4");
        cmd_valid = 1'b0;
        cyc("t4");
        cyc("t4");
        abort = 1'b1;
        cyc("t4");
        abort = 1'b0;
        chk("t4.busy", 32'(busy), 32'd0);
        chk("t4.out", 32'(dec_out), 32'd0);
        repeat (3) begin
            cyc("t4");
            chk("t4.nodone", 32'(done), 32'd0);
        end

        // 5: back-to-back with valid held
        cmd(MODE_DIRECT, 3'd3, 3'd0, 4'd0);
        cyc("t5");
        cmd_addr = 3'd4;
        cyc("t5");
        chk("t5.done", 32'(done), 32'd1);
        cyc("t5");
        cmd_valid = 1'b0;
        chk("t5.out", 32'(dec_out), 32'h10);
        drain("t5");

        // 6: async reset mid-scan
        cmd(MODE_SCAN, 3'd2, 3'd1, 4'd3);
        cyc("t6");
        cmd_valid = 1'b0;
        repeat (5) cyc("t6");
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6.out", 32'(dec_out), 32'd0);
        chk("t6.busy", 32'(busy), 32'd0);
        chk("t6.done", 32'(done), 32'd0);
        model_reset();
        cyc("t6r");
        #2;
        reset_n = 1'b1;
        check_all("t6rel");
        chk("t6.ready", 32'(cmd_ready), 32'd1);
        chk("t6.cur", 32'(cur_addr), 32'd0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_mode  = 1'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_last  = AW'($urandom);
            cmd_dwell = DW'($urandom_range(0, 3));
            enable    = ($urandom_range(0, 9) != 0);
            abort     = ($urandom_range(0, 29) == 0);
            cyc("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
